// File: rtl/alex_relay_sequencer_if.sv
// Request/drive bundle between the C&C register decode (master) and the
// Alex relay sequencer (slave). Widths follow the relay counts.
interface alex_relay_sequencer_if #(
  parameter int N_TX = 3,
  parameter int N_RX = 4
);
  localparam int TXW = $clog2(N_TX);
  localparam int RXW = $clog2(N_RX);

  // Requests from the register decode
  logic [TXW-1:0]  tx_sel;
  logic [RXW-1:0]  rx_sel;
  logic            rx1_out_req;

  // Relay drives and transmit gating back out
  logic [N_TX-1:0] ant_tx;
  logic [N_RX-2:0] rx_ant;
  logic            rx1_out;
  logic            tx_inhibit;
  logic            busy;

  modport master (
    output tx_sel, rx_sel, rx1_out_req,
    input  ant_tx, rx_ant, rx1_out, tx_inhibit, busy
  );

  modport slave (
    input  tx_sel, rx_sel, rx1_out_req,
    output ant_tx, rx_ant, rx1_out, tx_inhibit, busy
  );
endinterface

// File: rtl/alex_relay_sequencer.sv
// Alex antenna relay sequencer: decodes TX antenna, RX input and Rx_1_out
// requests into relay drives and wraps every relay change in an
// inhibit -> break -> switch -> settle sequence so relays never hot-switch.
module alex_relay_sequencer #(
  parameter int N_TX         = 3,
  parameter int N_RX         = 4,
  parameter int BREAK_CYCLES = 122880,
  parameter int MAKE_CYCLES  = 614400
) (
  input logic                  clk,
  input logic                  rst_n,
  alex_relay_sequencer_if.slave bus
);

  localparam int TXW  = $clog2(N_TX);
  localparam int RXW  = $clog2(N_RX);
  localparam int MAXC = (BREAK_CYCLES > MAKE_CYCLES) ? BREAK_CYCLES : MAKE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  // Counts are loaded with N-1 so the move/release lands exactly N edges later
  localparam logic [CW-1:0] BREAK_LOAD = CW'(BREAK_CYCLES - 1);
  localparam logic [CW-1:0] MAKE_LOAD  = CW'(MAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TXW-1:0] tx;
    logic [RXW-1:0] rx;
    logic           rx1;
  } req_t;

  req_t            w_req;
  req_t            w_tgt;
  logic            w_valid;
  logic            w_pending;
  logic            w_load;
  logic [N_TX-1:0] w_ant_tx;
  logic [N_RX-2:0] w_rx_ant;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  req_t            r_last;
  req_t            r_applied;
  logic [N_TX-1:0] r_ant_tx;
  logic [N_RX-2:0] r_rx_ant;
  logic            r_rx1_out;
  logic            r_tx_inhibit;
  logic            r_busy;

  // Request qualification, pending detection and one-hot decode of the target
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_ant_tx = '0;
    w_rx_ant = '0;

    w_req     = '{tx: bus.tx_sel, rx: bus.rx_sel, rx1: bus.rx1_out_req};
    w_valid   = (32'(w_req.tx) < N_TX) && (32'(w_req.rx) < N_RX);
    // Invalid requests fall back to the most recent valid one
    w_tgt     = w_valid ? w_req : r_last;
    w_pending = w_valid && (w_req != r_applied);

    // Relays move at the end of BREAK, or on any new request while settling
    w_load = ((r_state == ST_BREAK) && (r_cnt == '0)) ||
             ((r_state == ST_MAKE)  && w_pending);

    for (int i = 0; i < N_TX; i++) begin
      w_ant_tx[i] = (w_tgt.tx == TXW'(i));
    end
    // Code 0 means no RX input selected: all bits stay clear
    for (int j = 1; j < N_RX; j++) begin
      w_rx_ant[j-1] = (w_tgt.rx == RXW'(j));
    end
  end

  // Remember the latest valid request so an invalid one cannot steer a sequence
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is async active-low.
    if (!rst_n) begin
      r_last <= '0;
    end else begin
      r_last <= w_tgt;
    end
  end

  // Sequencer FSM with registered relay drives, inhibit and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Power-up behaves like a fresh relay move: full settle before TX is released
      r_state      <= ST_MAKE;
      r_cnt        <= MAKE_LOAD;
      r_applied    <= '0;
      r_ant_tx     <= N_TX'(1);
      r_rx_ant     <= '0;
      r_rx1_out    <= 1'b0;
      r_tx_inhibit <= 1'b1;
      r_busy       <= 1'b1;
    end else begin
      // Relay drives are loaded as whole one-hot words, never bit by bit
      if (w_load) begin
        r_applied <= w_tgt;
        r_ant_tx  <= w_ant_tx;
        r_rx_ant  <= w_rx_ant;
        r_rx1_out <= w_tgt.rx1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_state      <= ST_BREAK;
            r_cnt        <= BREAK_LOAD;
            r_tx_inhibit <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        ST_BREAK: begin
          if (r_cnt == '0) begin
            r_state <= ST_MAKE;
            r_cnt   <= MAKE_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_MAKE: begin
          if (w_pending) begin
            // Inhibit is already high, so a late change only restarts the settle
            r_cnt <= MAKE_LOAD;
          end else if (r_cnt == '0) begin
            r_state      <= ST_IDLE;
            r_tx_inhibit <= 1'b0;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: recover through a full settle with TX blocked
          r_state      <= ST_MAKE;
          r_cnt        <= MAKE_LOAD;
          r_tx_inhibit <= 1'b1;
          r_busy       <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ant_tx     = r_ant_tx;
  assign bus.rx_ant     = r_rx_ant;
  assign bus.rx1_out    = r_rx1_out;
  assign bus.tx_inhibit = r_tx_inhibit;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_alex_relay_sequencer.sv
// Self-checking bench for alex_relay_sequencer: directed scenarios followed by
// randomized requests and resets, compared every cycle against a timeline model
// that tracks when the relays are due to move and when TX is due to be released.
module tb_alex_relay_sequencer;

  localparam int N_TX = 3;
  localparam int N_RX = 4;
  localparam int B    = 4;
  localparam int M    = 8;
  localparam int TXW  = $clog2(N_TX);
  localparam int RXW  = $clog2(N_RX);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  alex_relay_sequencer_if #(.N_TX(N_TX), .N_RX(N_RX)) bus ();

  alex_relay_sequencer #(
    .N_TX        (N_TX),
    .N_RX        (N_RX),
    .BREAK_CYCLES(B),
    .MAKE_CYCLES (M)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: applied relay state plus the edges at which things are due
  int cyc        = 0;
  int m_tx       = 0;
  int m_rx       = 0;
  int m_rx1      = 0;
  bit m_inh      = 1'b1;
  int lv_tx      = 0;
  int lv_rx      = 0;
  int lv_rx1     = 0;
  int switch_at  = -1;
  int release_at = -1;

  logic [N_TX-1:0] prev_ant = N_TX'(1);
  logic [N_RX-2:0] prev_rx  = '0;
  logic            prev_rx1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tx       = 0;
    m_rx       = 0;
    m_rx1      = 0;
    m_inh      = 1'b1;
    lv_tx      = 0;
    lv_rx      = 0;
    lv_rx1     = 0;
    switch_at  = -1;
    release_at = cyc + M;
  endtask

  // Advance the model by one clock edge using the request present at that edge
  task automatic model_edge();
    int tx, rx, r1;
    bit valid, pending;
    cyc++;
    tx = int'(bus.tx_sel);
    rx = int'(bus.rx_sel);
    r1 = int'(bus.rx1_out_req);
    valid = (tx < N_TX) && (rx < N_RX);
    if (valid) begin
      lv_tx  = tx;
      lv_rx  = rx;
      lv_rx1 = r1;
    end
    pending = valid && ((tx != m_tx) || (rx != m_rx) || (r1 != m_rx1));
    if (!m_inh) begin
      if (pending) begin
        m_inh     = 1'b1;
        switch_at = cyc + B;
      end
    end else if (switch_at >= 0) begin
      if (cyc == switch_at) begin
        m_tx       = lv_tx;
        m_rx       = lv_rx;
        m_rx1      = lv_rx1;
        release_at = cyc + M;
        switch_at  = -1;
      end
    end else if (pending) begin
      m_tx       = tx;
      m_rx       = rx;
      m_rx1      = r1;
      release_at = cyc + M;
    end else if (cyc == release_at) begin
      m_inh      = 1'b0;
      release_at = -1;
    end
  endtask

  task automatic compare();
    int exp_ant, exp_rx;
    exp_ant = 1 << m_tx;
    exp_rx  = (m_rx == 0) ? 0 : (1 << (m_rx - 1));
    check("ant_tx",     32'(bus.ant_tx),     exp_ant);
    check("rx_ant",     32'(bus.rx_ant),     exp_rx);
    check("rx1_out",    32'(bus.rx1_out),    32'(m_rx1));
    check("tx_inhibit", 32'(bus.tx_inhibit), 32'(m_inh));
    check("busy",       32'(bus.busy),       32'(m_inh));
    check("ant_onehot", 32'($onehot(bus.ant_tx)),  32'd1);
    check("rx_onehot0", 32'($onehot0(bus.rx_ant)), 32'd1);
    if (!bus.tx_inhibit) begin
      check("hold_ant", 32'(bus.ant_tx),  32'(prev_ant));
      check("hold_rx",  32'(bus.rx_ant),  32'(prev_rx));
      check("hold_rx1", 32'(bus.rx1_out), 32'(prev_rx1));
    end
    prev_ant = bus.ant_tx;
    prev_rx  = bus.rx_ant;
    prev_rx1 = bus.rx1_out;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic set_req(input int tx, input int rx, input int r1);
    bus.tx_sel      = TXW'(tx);
    bus.rx_sel      = RXW'(rx);
    bus.rx1_out_req = r1[0];
  endtask

  // Assert reset, check the outputs react at once and stay put, then release
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    repeat (2) begin
      @(posedge clk);
      #1;
      compare();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    set_req(0, 0, 0);
    #2;
    do_reset();

    // Power-up settle with the default request held
    repeat (12) step();

    // TX antenna change from idle
    set_req(2, 0, 0);
    repeat (16) step();

    // RX request changes again inside BREAK: single move to the latest value
    set_req(2, 1, 0);
    repeat (2) step();
    set_req(2, 3, 0);
    repeat (16) step();

    // Rx_1_out toggled three clocks into MAKE restarts the settle
    set_req(1, 3, 0);
    repeat (B + 3) step();
    set_req(1, 3, 1);
    repeat (16) step();

    // Request returns to the applied state during BREAK
    set_req(0, 3, 1);
    repeat (2) step();
    set_req(1, 3, 1);
    repeat (16) step();

    // Invalid TX code from idle is ignored
    set_req(3, 3, 1);
    repeat (10) step();

    // Reset two clocks into BREAK
    set_req(2, 3, 1);
    repeat (2) step();
    set_req(0, 0, 0);
    do_reset();
    repeat (12) step();

    // Randomized requests (including invalid codes) and occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        set_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
